// File: rtl/nids_sched_pkg.sv
// rtl/nids_sched_pkg.sv - shared types, widths and helpers for the NIDS batch scheduler
// Contents: state_t (scheduler FSM states), FEAT_IDX_W, CNT_W, DEFAULT_TIMEOUT, sat_inc()
package nids_sched_pkg;

    localparam int FEAT_IDX_W      = 5;
    localparam int CNT_W           = 4;
    localparam int DEFAULT_TIMEOUT = 5000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_FIRE   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RECORD = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_FIRE   = ST_FIRE,
        S_WAIT   = ST_WAIT,
        S_RECORD = ST_RECORD,
        S_DONE   = ST_DONE
    } state_t;

    // Result counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nids_batch_scheduler_if.sv
// rtl/nids_batch_scheduler_if.sv - test-vector ROM, feature register file and detector bus
// master (scheduler): drives mem_addr, feat_we, feat_idx, feat_wdata, det_valid
//                     samples mem_rdata, det_valid_out, det_attack
// slave  (ROM + detector side): the reverse
interface nids_batch_scheduler_if
    import nids_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 9
);
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  feat_we;
    logic [FEAT_IDX_W-1:0] feat_idx;
    logic [DATA_WIDTH-1:0] feat_wdata;
    logic                  det_valid;
    logic                  det_valid_out;
    logic                  det_attack;

    modport master (
        output mem_addr, feat_we, feat_idx, feat_wdata, det_valid,
        input  mem_rdata, det_valid_out, det_attack
    );

    modport slave (
        input  mem_addr, feat_we, feat_idx, feat_wdata, det_valid,
        output mem_rdata, det_valid_out, det_attack
    );
endinterface

// File: rtl/nids_feature_fetch.sv
// rtl/nids_feature_fetch.sv - streams one test's feature words from the ROM into the detector
// clk, rst_n       : clock, asynchronous active-low reset
// go               : held high by the scheduler for the whole LOAD phase
// base_addr        : ROM address of feature 0 of the current test
// mem_rdata        : ROM data, valid one cycle after mem_addr
// last             : high in the cycle carrying the final feature write
// mem_addr         : ROM read address
// feat_we/feat_idx/feat_wdata : feature register file write port
module nids_feature_fetch
    import nids_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  last,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  feat_we,
    output logic [FEAT_IDX_W-1:0] feat_idx,
    output logic [DATA_WIDTH-1:0] feat_wdata
);
    localparam int K_W = FEAT_IDX_W + 1;

    // k counts LOAD cycles: cycle k issues address k and writes feature k-1,
    // so the phase spans N_FEATURES+1 cycles.
    logic [K_W-1:0] k;
    logic           issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (go && !last) begin
            k <= k + 1'b1;
        end else begin
            k <= '0;
        end
    end

    assign issue      = go && (k < K_W'(N_FEATURES));
    assign last       = go && (k == K_W'(N_FEATURES));
    assign mem_addr   = issue ? base_addr + ADDR_W'(k) : '0;
    assign feat_we    = go && (k != '0);
    assign feat_idx   = feat_we ? FEAT_IDX_W'(k - 1'b1) : '0;
    assign feat_wdata = feat_we ? mem_rdata : '0;

endmodule

// File: rtl/nids_batch_scheduler.sv
// rtl/nids_batch_scheduler.sv - runs the PCA detector over a batch of stored test vectors
// clk, rst_n   : clock, asynchronous active-low reset
// start, abort : single-cycle batch start / stop pulses (abort wins)
// bus          : ROM read port, feature write port and detector handshake (master side)
// exp_labels   : expected verdict per test
// busy, done   : batch running / batch complete (sticky)
// cur_test     : test in progress
// result_vec, attack_cnt, mismatch_cnt, timeout_cnt : recorded results
// Build option NIDS_SCHED_CONTINUOUS_EN: wrap to test 0 after the last test,
// pulsing done and clearing result_vec, until aborted.
module nids_batch_scheduler
    import nids_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28,
    parameter int N_TESTS    = 10,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int ADDR_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    nids_batch_scheduler_if.master bus,
    input  logic [N_TESTS-1:0]   exp_labels,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cur_test,
    output logic [N_TESTS-1:0]   result_vec,
    output logic [CNT_W-1:0]     attack_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CNT_W-1:0]     timeout_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic              verdict;
    logic [TMO_W-1:0]  tmo;
    logic              fetch_last;
    logic              last_test;
    logic [ADDR_W-1:0] base_addr;

    assign last_test = (cur_test == CNT_W'(N_TESTS - 1));
    assign base_addr = ADDR_W'(cur_test * N_FEATURES);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign bus.det_valid = (state == S_FIRE);

    nids_feature_fetch #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_FEATURES (N_FEATURES),
        .ADDR_W     (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (state == S_LOAD),
        .base_addr  (base_addr),
        .mem_rdata  (bus.mem_rdata),
        .last       (fetch_last),
        .mem_addr   (bus.mem_addr),
        .feat_we    (bus.feat_we),
        .feat_idx   (bus.feat_idx),
        .feat_wdata (bus.feat_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            verdict      <= 1'b0;
            tmo          <= '0;
            done         <= 1'b0;
            cur_test     <= '0;
            result_vec   <= '0;
            attack_cnt   <= '0;
            mismatch_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
`ifdef NIDS_SCHED_CONTINUOUS_EN
            // done is a one-cycle wrap marker in this build
            done <= 1'b0;
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        result_vec   <= '0;
                        attack_cnt   <= '0;
                        mismatch_cnt <= '0;
                        timeout_cnt  <= '0;
                        done         <= 1'b0;
                        cur_test     <= '0;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (fetch_last) begin
                        state <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        tmo   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the expiry cycle takes priority over the timeout.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (bus.det_valid_out) begin
                        verdict <= bus.det_attack;
                        state   <= S_RECORD;
                    end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                        verdict     <= 1'b0;
                        timeout_cnt <= sat_inc(timeout_cnt);
                        state       <= S_RECORD;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_RECORD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        result_vec[cur_test] <= verdict;
                        if (verdict) begin
                            attack_cnt <= sat_inc(attack_cnt);
                        end
                        if (verdict != exp_labels[cur_test]) begin
                            mismatch_cnt <= sat_inc(mismatch_cnt);
                        end
                        if (last_test) begin
`ifdef NIDS_SCHED_CONTINUOUS_EN
                            // later assignment overrides the bit written above
                            result_vec <= '0;
                            cur_test   <= '0;
                            done       <= 1'b1;
                            state      <= S_LOAD;
`else
                            done       <= 1'b1;
                            state      <= S_DONE;
`endif
                        end else begin
                            cur_test <= cur_test + 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
